// File: rtl/kfpga_config_loader.sv
// Serial configuration loader for the kFPGA core chain: clears the chain, then shifts host words LSB first.
// Optional trailer CRC check is compiled in with `define KFPGA_CONFIG_CRC_EN.
module kfpga_config_loader #(
    parameter int WORD_WIDTH   = 32,
    parameter int CHAIN_LENGTH = 20000,
    parameter int CLEAR_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  core_config_in,
    output logic                  core_config_enable,
    output logic                  core_config_nreset,
    output logic                  core_nreset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int RW = $clog2(CHAIN_LENGTH + 1);
    localparam int CW = $clog2(WORD_WIDTH + 1);
    localparam int KW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        SHIFT,
`ifdef KFPGA_CONFIG_CRC_EN
        CHECK,
`endif
        DONE
    } state_t;

    state_t                state;
    logic [RW-1:0]         remaining;
    logic [CW-1:0]         word_cnt;
    logic [KW-1:0]         clear_cnt;
    logic [WORD_WIDTH-1:0] shreg;

`ifdef KFPGA_CONFIG_CRC_EN
    logic [15:0] crc;
    logic        error_reg;
    logic        crc_fb;

    // Feedback uses the bit currently presented to the core, so the CRC covers exactly the chain contents.
    assign crc_fb = crc[15] ^ core_config_in;
    assign error  = error_reg;
`else
    assign error  = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!nreset) begin
            state              <= IDLE;
            word_ready         <= 1'b0;
            core_config_in     <= 1'b0;
            core_config_enable <= 1'b0;
            core_config_nreset <= 1'b1;
            core_nreset        <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            remaining          <= '0;
            word_cnt           <= '0;
            clear_cnt          <= '0;
            shreg              <= '0;
`ifdef KFPGA_CONFIG_CRC_EN
            crc                <= 16'hFFFF;
            error_reg          <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state              <= CLEAR;
                        clear_cnt          <= KW'(CLEAR_CYCLES - 1);
                        core_config_nreset <= 1'b0;
                        core_nreset        <= 1'b0;
                        busy               <= 1'b1;
                        done               <= 1'b0;
`ifdef KFPGA_CONFIG_CRC_EN
                        crc                <= 16'hFFFF;
                        error_reg          <= 1'b0;
`endif
                    end
                end
                CLEAR: begin
                    if (clear_cnt == '0) begin
                        state              <= LOAD;
                        core_config_nreset <= 1'b1;
                        word_ready         <= 1'b1;
                        remaining          <= RW'(CHAIN_LENGTH);
                    end else begin
                        clear_cnt <= clear_cnt - 1'b1;
                    end
                end
                LOAD: begin
                    if (word_valid && word_ready) begin
                        state              <= SHIFT;
                        word_ready         <= 1'b0;
                        core_config_enable <= 1'b1;
                        core_config_in     <= word_data[0];
                        shreg              <= word_data >> 1;
                        // The final partial word only carries the bits the chain still needs.
                        if (32'(remaining) >= WORD_WIDTH) begin
                            word_cnt <= CW'(WORD_WIDTH);
                        end else begin
                            word_cnt <= CW'(remaining);
                        end
                    end
                end
                SHIFT: begin
                    remaining <= remaining - 1'b1;
                    word_cnt  <= word_cnt - 1'b1;
`ifdef KFPGA_CONFIG_CRC_EN
                    crc       <= {crc[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
`endif
                    if (word_cnt == CW'(1)) begin
                        core_config_enable <= 1'b0;
                        core_config_in     <= 1'b0;
                        if (remaining == RW'(1)) begin
`ifdef KFPGA_CONFIG_CRC_EN
                            state      <= CHECK;
                            word_ready <= 1'b1;
`else
                            state       <= DONE;
                            done        <= 1'b1;
                            busy        <= 1'b0;
                            core_nreset <= 1'b1;
`endif
                        end else begin
                            state      <= LOAD;
                            word_ready <= 1'b1;
                        end
                    end else begin
                        core_config_in <= shreg[0];
                        shreg          <= shreg >> 1;
                    end
                end
`ifdef KFPGA_CONFIG_CRC_EN
                CHECK: begin
                    if (word_valid && word_ready) begin
                        state      <= DONE;
                        word_ready <= 1'b0;
                        busy       <= 1'b0;
                        // A mismatch leaves the chain loaded but keeps user logic in reset.
                        if (word_data[15:0] == crc) begin
                            done        <= 1'b1;
                            core_nreset <= 1'b1;
                        end else begin
                            error_reg <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_kfpga_config_loader.sv
// Self-checking bench for kfpga_config_loader: directed timing plus randomized loads against a bit-queue model.
module tb_kfpga_config_loader;
    localparam int WW = 32;
    localparam int CL = 40;
    localparam int CC = 4;
`ifdef KFPGA_CONFIG_CRC_EN
    localparam int CRC = 1;
`else
    localparam int CRC = 0;
`endif

    logic          clock = 1'b0;
    logic          nreset, start, word_valid;
    logic [WW-1:0] word_data;
    logic          word_ready, core_config_in, core_config_enable, core_config_nreset;
    logic          core_nreset, busy, done, error;

    logic          s_start, s_valid;
    logic [WW-1:0] s_data;
    logic          s_ready, s_in, s_en, s_cfg_nreset, s_core_nreset, s_busy, s_done, s_error;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    kfpga_config_loader #(.WORD_WIDTH(WW), .CHAIN_LENGTH(CL), .CLEAR_CYCLES(CC)) dut (
        .clock(clock), .nreset(nreset), .start(start), .word_data(word_data), .word_valid(word_valid),
        .word_ready(word_ready), .core_config_in(core_config_in), .core_config_enable(core_config_enable),
        .core_config_nreset(core_config_nreset), .core_nreset(core_nreset), .busy(busy), .done(done),
        .error(error));

    kfpga_config_loader #(.WORD_WIDTH(WW), .CHAIN_LENGTH(32), .CLEAR_CYCLES(CC)) dut32 (
        .clock(clock), .nreset(nreset), .start(s_start), .word_data(s_data), .word_valid(s_valid),
        .word_ready(s_ready), .core_config_in(s_in), .core_config_enable(s_en),
        .core_config_nreset(s_cfg_nreset), .core_nreset(s_core_nreset), .busy(s_busy), .done(s_done),
        .error(s_error));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc16(input bit b[$]);
        logic [15:0] c = 16'hFFFF;
        foreach (b[i]) c = (c << 1) ^ (((c[15] ^ b[i]) != 1'b0) ? 16'h1021 : 16'h0000);
        return c;
    endfunction

    task automatic check_reset(input string where);
        chk({where, " word_ready"}, 64'(word_ready), 64'(0));
        chk({where, " config_in"}, 64'(core_config_in), 64'(0));
        chk({where, " config_enable"}, 64'(core_config_enable), 64'(0));
        chk({where, " config_nreset"}, 64'(core_config_nreset), 64'(1));
        chk({where, " core_nreset"}, 64'(core_nreset), 64'(0));
        chk({where, " busy"}, 64'(busy), 64'(0));
        chk({where, " done"}, 64'(done), 64'(0));
        chk({where, " error"}, 64'(error), 64'(0));
    endtask

    // Cycle-accurate walk of the 40-bit two-word load, cycle 0 being the start cycle.
    task automatic directed_timing();
        logic [WW-1:0] w[3];
        logic [WW-1:0] wa;
        bit            bits[$];
        int            idx = 0;
        int            done_c = 47 + CRC;
        logic [6:0]    exp_v, obs_v;
        bit            en, b;
        w[0] = 32'hA5A5A5A5;
        w[1] = 32'h000000FF;
        wa = w[0];
        for (int i = 0; i < CL; i++) bits.push_back(i < 32 ? wa[i] : 1'b1);
        w[2] = {16'h0000, crc16(bits)};
        for (int c = 0; c <= done_c + 1; c++) begin
            en = (c >= 6 && c <= 37) || (c >= 39 && c <= 46);
            b = (c >= 6 && c <= 37) ? wa[c-6] : en;
            exp_v = {!(c >= 1 && c <= 4), (c == 5 || c == 38 || (CRC == 1 && c == 47)), en, b,
                     (c >= done_c), (c >= 1 && c < done_c), (c >= done_c)};
            obs_v = {core_config_nreset, word_ready, core_config_enable, core_config_enable & core_config_in,
                     done, busy, core_nreset};
            chk($sformatf("timing c=%0d {cfgn,rdy,en,bit,done,busy,nrst}", c), 64'(obs_v), 64'(exp_v));
            start = (c == 0);
            word_valid = 1'b1;
            word_data = (idx < 3) ? w[idx] : '0;
            if (word_ready) idx++;
            @(negedge clock);
        end
        start = 1'b0;
        word_valid = 1'b0;
    endtask

    task automatic run_load(input int stall_lo, input int stall_hi, input bit start_mid, input bit bad_crc,
                            input bit zeros, input int abort_at, input string name);
        int            nw = (CL + WW - 1) / WW;
        logic [WW-1:0] w[$];
        logic [WW-1:0] t;
        bit            exp_bits[$];
        bit            got[$];
        int            idx = 0, accepted = 0, cycles = 0, stall, bad_stall = 0;
        bit            pulsed = 0, exp_err;
        logic [CL-1:0] gv = '0, ev = '0;
        for (int i = 0; i < nw; i++) w.push_back(zeros ? '0 : WW'($urandom()));
        for (int i = 0; i < CL; i++) begin
            t = w[i / WW];
            exp_bits.push_back(t[i % WW]);
        end
`ifdef KFPGA_CONFIG_CRC_EN
        t = WW'($urandom());
        t[15:0] = crc16(exp_bits) ^ {15'b0, bad_crc};
        w.push_back(t);
`endif
        stall = $urandom_range(stall_hi, stall_lo);
        start = 1'b1;
        word_valid = 1'b0;
        @(negedge clock);
        chk({name, " restart flags {done,error,busy,nrst}"}, 64'({done, error, busy, core_nreset}), 64'(4'b0010));
        while (!(done || error) && cycles < 3000) begin
            if (core_config_enable) got.push_back(core_config_in);
            if (word_ready && core_config_enable) bad_stall++;
            if (abort_at > 0 && got.size() == abort_at) begin
                nreset = 1'b0;
                start = 1'b0;
                word_valid = 1'b0;
                @(negedge clock);
                check_reset({name, " mid-shift reset"});
                nreset = 1'b1;
                @(negedge clock);
                return;
            end
            start = start_mid && !pulsed && core_config_enable && got.size() == 5;
            if (start) pulsed = 1'b1;
            if (stall > 0) begin
                word_valid = 1'b0;
                if (word_ready) stall--;
            end else begin
                word_valid = 1'b1;
                word_data = (idx < w.size()) ? w[idx] : WW'($urandom());
                if (word_ready) begin
                    idx++;
                    accepted++;
                    stall = $urandom_range(stall_hi, stall_lo);
                end
            end
            @(negedge clock);
            cycles++;
        end
        start = 1'b0;
        word_valid = 1'b0;
        for (int i = 0; i < CL; i++) begin
            ev[i] = exp_bits[i];
            if (i < got.size()) gv[i] = got[i];
        end
        exp_err = (CRC == 1) && bad_crc;
        chk({name, " finished in budget"}, 64'(cycles < 3000), 64'(1));
        chk({name, " bit count"}, 64'(got.size()), 64'(CL));
        chk({name, " serial stream"}, 64'(gv), 64'(ev));
        chk({name, " words accepted"}, 64'(accepted), 64'(nw + CRC));
        chk({name, " ready with enable"}, 64'(bad_stall), 64'(0));
        chk({name, " end {done,error,busy,nrst}"}, 64'({done, error, busy, core_nreset}),
            64'({!exp_err, exp_err, 1'b0, !exp_err}));
    endtask

    task automatic run32();
        logic [WW-1:0] wd, tr;
        bit            eb[$];
        bit            gb[$];
        int            readies = 0, cyc = 0, post = 0;
        logic [31:0]   gv = '0;
        wd = WW'($urandom());
        tr = WW'($urandom());
        for (int i = 0; i < 32; i++) eb.push_back(wd[i]);
`ifdef KFPGA_CONFIG_CRC_EN
        tr[15:0] = crc16(eb);
`endif
        s_start = 1'b1;
        s_valid = 1'b1;
        s_data = wd;
        @(negedge clock);
        s_start = 1'b0;
        while (post < 6 && cyc < 500) begin
            if (s_en) gb.push_back(s_in);
            if (s_done || s_error) post++;
            s_data = (readies == 0) ? wd : tr;
            if (s_ready) readies++;
            @(negedge clock);
            cyc++;
        end
        s_valid = 1'b0;
        foreach (gb[i]) if (i < 32) gv[i] = gb[i];
        chk("len32 finished in budget", 64'(cyc < 500), 64'(1));
        chk("len32 ready cycles", 64'(readies), 64'(1 + CRC));
        chk("len32 enable cycles", 64'(gb.size()), 64'(32));
        chk("len32 serial stream", 64'(gv), 64'(wd));
        chk("len32 end {done,error,nrst}", 64'({s_done, s_error, s_core_nreset}), 64'(3'b101));
    endtask

    initial begin
        nreset = 1'b0;
        start = 1'b0;
        word_valid = 1'b0;
        word_data = '0;
        s_start = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        repeat (3) @(negedge clock);
        check_reset("power-on reset");
        nreset = 1'b1;
        @(negedge clock);
        directed_timing();
        run_load(0, 0, 0, 0, 0, 0, "back-to-back");
        run_load(20, 20, 0, 0, 0, 0, "stall20");
        run_load(0, 3, 1, 0, 0, 0, "start-in-shift");
        run_load(0, 0, 0, 0, 0, 10, "abort");
        run_load(0, 2, 0, 0, 0, 0, "after-abort");
        run_load(0, 0, 0, 0, 1, 0, "zeros-good");
        run_load(0, 0, 0, 1, 1, 0, "zeros-badcrc");
        for (int k = 0; k < 4; k++) run_load(0, 6, 0, k[0], 0, 0, $sformatf("random%0d", k));
        run32();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/kfpga_config_loader.md
Name: kfpga_config_loader

Overview:
Bitstream loader for the kFPGA core's serial configuration chain. Accepts configuration words from a host over a valid/ready stream and clears the chain. Shifts exactly CHAIN_LENGTH bits into the core, LSB first. Holds the core's user reset low until loading completes. Sits between the SoC/host bus adapter and the core's config_in/config_enable/config_nreset/nreset pins.

Parameters:
WORD_WIDTH, 32, width of host configuration words.
CHAIN_LENGTH, 20000, total configuration bits in the core chain; need not be a multiple of WORD_WIDTH.
CLEAR_CYCLES, 4, cycles core_config_nreset is held low before loading.

Ports:
clock  input  1  system clock; all logic on rising edge
nreset  input  1  synchronous active-low reset
start  input  1  one-cycle pulse; begins a load when idle or done
word_data  input  WORD_WIDTH  configuration word; bit 0 is shifted first
word_valid  input  1  host word valid
word_ready  output  1  loader accepts word this cycle
core_config_in  output  1  serial bit to core config_in
core_config_enable  output  1  chain shift enable to core
core_config_nreset  output  1  chain clear to core, active-low
core_nreset  output  1  user-logic reset to core, active-low
busy  output  1  load in progress (CLEAR..SHIFT)
done  output  1  chain fully loaded; held until next start or reset
error  output  1  load failed (CRC build only); held until next start or reset

Behaviour:
- Reset (nreset low at clock edge) has priority over everything, including mid-load. State goes to IDLE. Reset values: word_ready=0, core_config_in=0, core_config_enable=0, core_config_nreset=1, core_nreset=0, busy=0, done=0, error=0. Bit counter is cleared.
- FSM states: IDLE, CLEAR, LOAD, SHIFT, CHECK (CRC build only), DONE.
- IDLE/DONE: start=1 -> CLEAR. done and error clear, core_nreset=0 and busy=1 from the next cycle. start in CLEAR/LOAD/SHIFT/CHECK is ignored.
- CLEAR: core_config_nreset=0 for exactly CLEAR_CYCLES cycles, then LOAD. Remaining bit count is set to CHAIN_LENGTH.
- LOAD: word_ready=1. On word_valid&&word_ready, word_data is latched into the shift register; n = min(WORD_WIDTH, remaining) -> SHIFT. With no word_valid, the loader waits indefinitely; outputs are stable and core_config_enable=0.
- SHIFT: core_config_enable=1 for exactly n consecutive cycles. core_config_in = shreg[0], and shreg shifts right each cycle. Remaining bits decrement per shifted bit. word_ready=0.
- After the last bit of a word: remaining>0 -> LOAD. remaining==0 -> DONE, or CHECK in the CRC build.
- Last partial word: only the low (CHAIN_LENGTH mod WORD_WIDTH) bits are shifted; upper bits are discarded.
- Throughput per full word: 1 accept cycle + WORD_WIDTH shift cycles. A word can be accepted the cycle after the last shift.
- DONE: done=1, busy=0, core_nreset=1, core_config_enable=0, core_config_nreset=1.
- Counter widths: $clog2(CHAIN_LENGTH+1) for remaining, $clog2(WORD_WIDTH+1) for per-word count. No wrap-around is permitted.

Optional Feature:
Macro KFPGA_CONFIG_CRC_EN.
- Defined:
  - A CRC-16-CCITT (poly 0x1021, init 0xFFFF, bit-serial, input bit = core_config_in, no reflection, no final XOR) is updated on every shifted bit.
  - After the last chain bit the FSM enters CHECK with word_ready=1 and accepts one trailer word; its low 16 bits are compared with the CRC.
  - Match -> DONE (core_nreset=1).
  - Mismatch -> DONE state with done=0, error=1, core_nreset held 0, busy=0. The chain is not cleared.
- Not defined: no CHECK state, no trailer word, error tied 0.

Test Plan:
- Reset mid-SHIFT (CHAIN_LENGTH=40, assert nreset=0 after 10 bits) -> next cycle all outputs at reset values, state IDLE; a fresh start loads normally.
- CHAIN_LENGTH=40, CLEAR_CYCLES=4, words 0xA5A5A5A5, 0x000000FF presented back-to-back, start at cycle 0:
  - core_config_nreset low cycles 1-4.
  - word_ready cycle 5.
  - core_config_enable high cycles 6-37, serial pattern 1,0,1,0,0,1,0,1...
  - 2nd word accepted cycle 38; 8 bits of 1 shifted cycles 39-46.
  - done=1 and core_nreset=1 from cycle 47.
- Host stalls word_valid=0 for 20 cycles in LOAD -> core_config_enable stays 0, bit counter unchanged, load resumes with identical serial stream.
- start pulsed during SHIFT and again in DONE -> first ignored; second clears done, reruns CLEAR, reloads the chain.
- CRC build, bitstream 40 zero bits: correct trailer -> done=1, core_nreset=1. Trailer XOR 0x0001 -> error=1, done=0, core_nreset=0.
- CHAIN_LENGTH=32 (exact multiple): exactly one word accepted, 32 enable cycles, then DONE; word_ready never reasserts.
